jelly_unsigned_square_multicycle: RTL

Multicycle unsigned squarer: accepts a DATA_WIDTH-bit operand over a valid/ready stream and returns its exact 2*DATA_WIDTH-bit square after DATA_WIDTH shift-add iterations. It is the inverse companion of the multicycle square-root unit in the math library. It is used to verify and round-trip sqrt results, and for low-area magnitude computation where a DSP multiplier is not wanted. It uses one operand in flight at a time and no multiplier primitives.

---
 rtl/jelly_unsigned_square_multicycle_pkg.sv | 12 +
 rtl/jelly_unsigned_square_multicycle.sv | 120 ++++++++++++
 2 files changed

// File: rtl/jelly_unsigned_square_multicycle_pkg.sv
// Shared types for the multicycle unsigned squarer.
package jelly_unsigned_square_multicycle_pkg;

  // ST_INIT is the post-reset state in which s_ready has not yet risen.
  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } sq_state_t;

endpackage

// File: rtl/jelly_unsigned_square_multicycle.sv
// Multicycle unsigned squarer: one operand in flight, DATA_WIDTH shift-add
// iterations, no multiplier primitives.
module jelly_unsigned_square_multicycle
  import jelly_unsigned_square_multicycle_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      reset,
  input  logic                      clk,
  input  logic                      cke,

  input  logic [DATA_WIDTH-1:0]     s_data,
  input  logic                      s_valid,
  output logic                      s_ready,

  output logic [2*DATA_WIDTH-1:0]   m_data,
  output logic                      m_valid,
  input  logic                      m_ready
);

  localparam int CNT_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  sq_state_t                 state_q,   state_d;
  logic [DATA_WIDTH-1:0]     x_q,       x_d;
  logic [DATA_WIDTH-1:0]     op_q,      op_d;
  logic [2*DATA_WIDTH-1:0]   acc_q,     acc_d;
  logic [CNT_WIDTH-1:0]      cnt_q,     cnt_d;
  logic                      s_ready_q, s_ready_d;
  logic                      m_valid_q, m_valid_d;

  logic [2*DATA_WIDTH-1:0]   addend;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_INIT;
      x_q       <= '0;
      op_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
    end else if (cke) begin
      state_q   <= state_d;
      x_q       <= x_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
    end
  end

  // MSB-first shift-add: each step doubles the partial sum and adds x when
  // the current multiplier bit (op MSB) is set.
  always_comb begin
    addend = '0;
    if (op_q[DATA_WIDTH-1]) begin
      addend = {{DATA_WIDTH{1'b0}}, x_q};
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    op_d      = op_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    s_ready_d = s_ready_q;
    m_valid_d = m_valid_q;

    case (state_q)
      ST_INIT: begin
        s_ready_d = 1'b1;
        state_d   = ST_IDLE;
      end

      ST_IDLE: begin
        if (s_valid && s_ready_q) begin
          x_d       = s_data;
          op_d      = s_data;
          acc_d     = '0;
          cnt_d     = CNT_LAST;
          s_ready_d = 1'b0;
          state_d   = ST_BUSY;
        end
      end

      ST_BUSY: begin
        acc_d = (acc_q << 1) + addend;
        op_d  = op_q << 1;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == '0) begin
          m_valid_d = 1'b1;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          s_ready_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        s_ready_d = 1'b0;
        m_valid_d = 1'b0;
        state_d   = ST_INIT;
      end
    endcase
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = acc_q;

endmodule
